alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 64: operand and result width.
REQ-002 SHALL have parameter SHAMT_W, default 6: shift-amount width, log2(DATA_W).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: request present.
REQ-006 SHALL have port in_ready  output  1: block can accept a request.
REQ-007 SHALL have port Optype  input  5: operation code from the ALU control decoder.
REQ-008 SHALL have ports src1 and src2  input  DATA_W each: operands.
REQ-009 SHALL have port flush  input  1: synchronous abort of the in-flight operation.
REQ-010 SHALL have port out_valid  output  1: result available.
REQ-011 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-012 SHALL have port result  output  DATA_W: operation result.
REQ-013 SHALL have port taken  output  1: branch condition true; 0 for non-branch ops.
REQ-014 SHALL have port illegal  output  1: Optype not in the supported set.

Function
REQ-015 SHALL decode Optype as: 00000 ADD, 00001 SLL, 00010 SLT (signed), 00011 SLTU, 00100 XOR, 00101 SRL, 00110 OR, 00111 AND, 01000 SUB, 01101 SRA, 11000 BEQ, 11001 BNE; every other code is illegal.
REQ-016 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid && in_ready.
REQ-018 SHALL, on acceptance of a non-shift or illegal op, register result/taken/illegal and enter DONE next cycle (latency 1).
REQ-019 SHALL, on acceptance of SLL/SRL/SRA with shamt=src2[SHAMT_W-1:0] nonzero, enter SHIFT and shift one bit per cycle; DONE is reached shamt cycles after acceptance.
REQ-020 SHALL, for a shift op with shamt==0, enter DONE after one cycle with result=src1.
REQ-021 SHALL fill SRA with src1[DATA_W-1]; SHALL fill SLL and SRL with zeros.
REQ-022 SHALL wrap ADD/SUB modulo 2^DATA_W; no overflow flag.
REQ-023 SHALL give SLT/SLTU result in bit 0 only, zero-extended.
REQ-024 SHALL, for BEQ/BNE, set taken to (src1==src2) or (src1!=src2) respectively, with result = {DATA_W-1 zeros, taken}.
REQ-025 SHALL, for an illegal op, give result=0, taken=0, illegal=1.
REQ-026 SHALL assert out_valid only in DONE; result/taken/illegal stable while out_valid && !out_ready.
REQ-027 SHALL, in DONE with out_ready=1, return to IDLE next cycle; no back-to-back accept in the same cycle.
REQ-028 SHALL give flush priority over all transitions: next state IDLE, out_valid deasserted, any result discarded; a request presented in the same cycle as flush is not accepted.
REQ-029 SHALL sample operands and Optype only on acceptance; input changes afterwards do not affect the in-flight operation.

Reset
REQ-030 SHALL, on rst asserted, immediately set state=IDLE, out_valid=0, result=0, taken=0, illegal=0, shift counter=0, regardless of state, including mid-SHIFT.
REQ-031 SHALL drive in_ready=1 on the first rising edge after rst deasserts.

Structure
REQ-032 SHALL place the Optype code constants and the FSM state enumeration in shared package alu_pkg, also used by the ALU control decoder.
REQ-033 SHALL implement the iterative shifter (operand register, down-counter, direction/arith select, done flag) as sub-module alu_shifter; all remaining logic stays in alu_exec.

Verification
REQ-034 SHALL cover ADD: src1=64'hFFFF_FFFF_FFFF_FFFF, src2=1, Optype=00000 -> out_valid one cycle after accept, result=0.
REQ-035 SHALL cover SRA: src1=64'h8000_0000_0000_0000, src2=4, Optype=01101 -> out_valid 4 cycles after accept, result=64'hF800_0000_0000_0000.
REQ-036 SHALL cover SLT vs SLTU: src1=-1, src2=1 -> SLT gives result=1 and SLTU gives result=0.
REQ-037 SHALL cover BNE with backpressure: src1=src2=5, Optype=11001, out_ready=0 for 3 cycles -> taken=0, result=0 held stable, IDLE one cycle after out_ready=1.
REQ-038 SHALL cover flush: SLL with shamt=40, flush asserted on cycle 10 -> IDLE next cycle, no out_valid, next ADD completes correctly.
REQ-039 SHALL cover illegal op and reset: Optype=10011 -> illegal=1, result=0; rst asserted mid-SHIFT -> all outputs 0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: Optype codes, FSM state encodings and decode helpers.
// Used by alu_exec and by the upstream ALU control decoder.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SLT  = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01101;
    localparam logic [4:0] OP_BEQ  = 5'b11000;
    localparam logic [4:0] OP_BNE  = 5'b11001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic op_is_shift(input logic [4:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bus of alu_exec: valid/ready request side, operands, flush,
// and valid/ready result side.
interface alu_exec_if #(parameter int DATA_W = 64);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        Optype;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              taken;
    logic              illegal;

    modport master (
        output in_valid, Optype, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, taken, illegal
    );

    modport slave (
        input  in_valid, Optype, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, taken, illegal
    );
endinterface

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter. The first shift is applied on the start
// cycle itself, so a shift by N finishes N cycles after the request is accepted.
module alu_shifter #(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_start,
    input  logic               i_left,
    input  logic               i_arith,
    input  logic [DATA_W-1:0]  i_opnd,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_done,
    output logic [DATA_W-1:0]  o_next
);

    logic [DATA_W-1:0]  r_opnd;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic               r_arith;
    logic [DATA_W-1:0]  w_src;
    logic               w_left;
    logic               w_arith;

    // On the start cycle the shift stage works on the live operand, afterwards on the register.
    assign w_src   = i_start ? i_opnd  : r_opnd;
    assign w_left  = i_start ? i_left  : r_left;
    assign w_arith = i_start ? i_arith : r_arith;

    assign o_next = w_left ? {w_src[DATA_W-2:0], 1'b0}
                           : {w_arith & w_src[DATA_W-1], w_src[DATA_W-1:1]};
    assign o_done = !i_start && (r_cnt == SHAMT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opnd  <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_opnd  <= o_next;
            r_left  <= i_left;
            r_arith <= i_arith;
            r_cnt   <= (i_shamt > SHAMT_W'(1)) ? i_shamt - SHAMT_W'(1) : '0;
        end else if (r_cnt != '0) begin
            r_opnd <= o_next;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage: single-cycle arithmetic/logic/branch ops and
// iterative shifts, with valid/ready handshakes on both sides and a flush.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    alu_exec_if.slave  bus
);

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_result;
    logic               r_taken;
    logic               r_illegal;

    logic               w_accept;
    logic               w_is_shift;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_sh_done;
    logic [DATA_W-1:0]  w_sh_next;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_alu_tk;
    logic               w_alu_ill;

    assign w_shamt    = bus.src2[SHAMT_W-1:0];
    assign w_is_shift = op_is_shift(bus.Optype);
    assign w_accept   = bus.in_valid && (r_state == ST_IDLE) && !bus.flush;

    alu_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (bus.flush),
        .i_start (w_accept && w_is_shift),
        .i_left  (bus.Optype == OP_SLL),
        .i_arith (bus.Optype == OP_SRA),
        .i_opnd  (bus.src1),
        .i_shamt (w_shamt),
        .o_done  (w_sh_done),
        .o_next  (w_sh_next)
    );

    always_comb begin
        w_alu_res = '0;
        w_alu_tk  = 1'b0;
        w_alu_ill = 1'b0;
        case (bus.Optype)
            OP_ADD:  w_alu_res = bus.src1 + bus.src2;
            OP_SUB:  w_alu_res = bus.src1 - bus.src2;
            OP_XOR:  w_alu_res = bus.src1 ^ bus.src2;
            OP_OR:   w_alu_res = bus.src1 | bus.src2;
            OP_AND:  w_alu_res = bus.src1 & bus.src2;
            OP_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, $signed(bus.src1) < $signed(bus.src2)};
            OP_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, bus.src1 < bus.src2};
            // Only shifts of 0 or 1 complete here; longer ones go through SHIFT.
            OP_SLL, OP_SRL, OP_SRA:
                     w_alu_res = (w_shamt == '0) ? bus.src1 : w_sh_next;
            OP_BEQ: begin
                w_alu_tk  = (bus.src1 == bus.src2);
                w_alu_res = {{(DATA_W-1){1'b0}}, bus.src1 == bus.src2};
            end
            OP_BNE: begin
                w_alu_tk  = (bus.src1 != bus.src2);
                w_alu_res = {{(DATA_W-1){1'b0}}, bus.src1 != bus.src2};
            end
            default: w_alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift && (w_shamt > SHAMT_W'(1))) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state   <= ST_DONE;
                            r_result  <= w_alu_res;
                            r_taken   <= w_alu_tk;
                            r_illegal <= w_alu_ill;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_sh_done) begin
                        r_state   <= ST_DONE;
                        r_result  <= w_sh_next;
                        r_taken   <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.taken     = r_taken;
    assign bus.illegal   = r_illegal;

endmodule
